// File: rtl/vga_clut_csm_pb.sv
// Two Wishbone slave ports time-share one synchronous CLUT RAM, one access per clock.
// Port 0 is the VGA fetch side and port 1 the host side; ties are broken round robin.
module vga_clut_csm_pb #(
  parameter int DWIDTH = 24,
  parameter int AWIDTH = 9
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [AWIDTH-1:0]     wb_adr0_i,
  input  logic [DWIDTH-1:0]     wb_dat0_i,
  output logic [DWIDTH-1:0]     wb_dat0_o,
  input  logic [DWIDTH/8-1:0]   wb_sel0_i,
  input  logic                  wb_we0_i,
  input  logic                  wb_stb0_i,
  input  logic                  wb_cyc0_i,
  output logic                  wb_ack0_o,
  output logic                  wb_err0_o,
  input  logic [AWIDTH-1:0]     wb_adr1_i,
  input  logic [DWIDTH-1:0]     wb_dat1_i,
  output logic [DWIDTH-1:0]     wb_dat1_o,
  input  logic [DWIDTH/8-1:0]   wb_sel1_i,
  input  logic                  wb_we1_i,
  input  logic                  wb_stb1_i,
  input  logic                  wb_cyc1_i,
  output logic                  wb_ack1_o,
  output logic                  wb_err1_o,
  output logic                  mem_we,
  output logic [AWIDTH-1:0]     mem_wadr,
  output logic [AWIDTH-1:0]     mem_radr,
  output logic [DWIDTH-1:0]     mem_d,
  input  logic [DWIDTH-1:0]     mem_q
);

  logic w_req0, w_req1;
  logic w_gnt0, w_gnt1;
  logic r_ack0, r_ack1;
  logic r_last;          // 1: port 1 was granted most recently
  logic w_unused_sel;

  // A port with its ack up is mid-handshake and must not be served again.
  always_comb begin
    w_req0 = wb_cyc0_i & wb_stb0_i & ~r_ack0;
    w_req1 = wb_cyc1_i & wb_stb1_i & ~r_ack1;
    w_gnt0 = ~wb_rst_i & w_req0 & (~w_req1 | r_last);
    w_gnt1 = ~wb_rst_i & w_req1 & (~w_req0 | ~r_last);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_last <= 1'b1;
    end else begin
      r_ack0 <= w_gnt0;
      r_ack1 <= w_gnt1;
      if (w_gnt0)      r_last <= 1'b0;
      else if (w_gnt1) r_last <= 1'b1;
    end
  end

  // Port 0 owns the memory bus whenever port 1 is not granted.
  assign mem_we   = (w_gnt0 & wb_we0_i) | (w_gnt1 & wb_we1_i);
  assign mem_radr = w_gnt1 ? wb_adr1_i : wb_adr0_i;
  assign mem_wadr = w_gnt1 ? wb_adr1_i : wb_adr0_i;
  assign mem_d    = w_gnt1 ? wb_dat1_i : wb_dat0_i;

  assign wb_dat0_o = mem_q;
  assign wb_dat1_o = mem_q;
  assign wb_ack0_o = r_ack0;
  assign wb_ack1_o = r_ack1;
  assign wb_err0_o = 1'b0;
  assign wb_err1_o = 1'b0;

  // Full-word writes only; byte selects carry no meaning here.
  assign w_unused_sel = ^{wb_sel0_i, wb_sel1_i};

endmodule

// File: tb/tb_vga_clut_csm_pb.sv
// Randomized bench for vga_clut_csm_pb: transaction-level masters, a shadow memory
// and a round-robin grant predictor derived from the arbitration rules.
module tb_vga_clut_csm_pb;
  localparam int DW = 24;
  localparam int AW = 9;

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [2:0]    sel;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] t_adr [2];
  logic [DW-1:0] t_dat [2];
  logic [DW-1:0] t_q   [2];
  logic [2:0]    t_sel [2];
  logic          t_we  [2];
  logic          t_stb [2];
  logic          t_cyc [2];
  logic          t_ack [2];
  logic          t_err [2];
  logic          mem_we;
  logic [AW-1:0] mem_wadr, mem_radr;
  logic [DW-1:0] mem_d, mem_q;

  always #5 clk = ~clk;

  vga_clut_csm_pb #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wb_adr0_i(t_adr[0]), .wb_dat0_i(t_dat[0]), .wb_dat0_o(t_q[0]), .wb_sel0_i(t_sel[0]),
    .wb_we0_i(t_we[0]), .wb_stb0_i(t_stb[0]), .wb_cyc0_i(t_cyc[0]),
    .wb_ack0_o(t_ack[0]), .wb_err0_o(t_err[0]),
    .wb_adr1_i(t_adr[1]), .wb_dat1_i(t_dat[1]), .wb_dat1_o(t_q[1]), .wb_sel1_i(t_sel[1]),
    .wb_we1_i(t_we[1]), .wb_stb1_i(t_stb[1]), .wb_cyc1_i(t_cyc[1]),
    .wb_ack1_o(t_ack[1]), .wb_err1_o(t_err[1]),
    .mem_we(mem_we), .mem_wadr(mem_wadr), .mem_radr(mem_radr), .mem_d(mem_d), .mem_q(mem_q)
  );

  // External synchronous RAM: q valid the cycle after the read address.
  logic [DW-1:0] ram [1<<AW];
  always @(posedge clk) begin
    if (mem_we) ram[mem_wadr] <= mem_d;
    mem_q <= ram[mem_radr];
  end

  int            checks = 0, errors = 0;
  logic          exp_ack [2];
  logic          exp_rd  [2];
  logic          exp_dv  [2];
  logic [DW-1:0] exp_dat [2];
  int            last;
  logic [DW-1:0] shadow [int];
  txn_t          qu0[$], qu1[$];
  txn_t          cur [2];
  logic          act [2];
  int            nacks [2];
  int            issue_pct, abort_pct;
  logic          rst_drv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    int   g;
    logic req [2];
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("ack%0d", p), t_ack[p], exp_ack[p]);
      chk($sformatf("err%0d", p), t_err[p], 1'b0);
      if (exp_ack[p] && exp_rd[p] && exp_dv[p])
        chk($sformatf("rdat%0d", p), t_q[p], exp_dat[p]);
    end
    for (int p = 0; p < 2; p++) begin
      if (exp_ack[p]) begin
        act[p] = 1'b0;
        nacks[p]++;
      end
      if (!act[p]) begin
        if ($urandom_range(99) < issue_pct) begin
          if (p == 0 && qu0.size() > 0) begin cur[0] = qu0.pop_front(); act[0] = 1'b1; end
          if (p == 1 && qu1.size() > 0) begin cur[1] = qu1.pop_front(); act[1] = 1'b1; end
        end
      end else if (!exp_ack[p] && $urandom_range(99) < abort_pct) begin
        act[p] = 1'b0;
      end
      t_cyc[p] = act[p];
      t_stb[p] = act[p];
      t_we[p]  = act[p] & cur[p].we;
      t_adr[p] = cur[p].adr;
      t_dat[p] = cur[p].dat;
      t_sel[p] = cur[p].sel;
      req[p]   = act[p] && !exp_ack[p] && !rst_drv;
    end
    rst = rst_drv;
    g = -1;
    if (req[0] && req[1]) g = (last == 0) ? 1 : 0;
    else if (req[0])      g = 0;
    else if (req[1])      g = 1;
    #1;
    chk("mem_we", mem_we, (g >= 0) ? cur[g].we : 1'b0);
    if (g >= 0) begin
      chk("mem_radr", mem_radr, cur[g].adr);
      chk("mem_wadr", mem_wadr, cur[g].adr);
      if (cur[g].we) chk("mem_d", mem_d, cur[g].dat);
    end
    for (int p = 0; p < 2; p++) exp_ack[p] = (g == p);
    if (g >= 0) begin
      last      = g;
      exp_rd[g] = !cur[g].we;
      if (cur[g].we) shadow[int'(cur[g].adr)] = cur[g].dat;
      else begin
        exp_dv[g] = shadow.exists(int'(cur[g].adr));
        if (exp_dv[g]) exp_dat[g] = shadow[int'(cur[g].adr)];
      end
    end
    if (rst_drv) last = 1;
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((qu0.size() > 0 || qu1.size() > 0 || act[0] || act[1] || exp_ack[0] || exp_ack[1])
           && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", budget);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [2:0] s);
    txn_t t;
    t.we = we; t.adr = a; t.dat = d; t.sel = s;
    return t;
  endfunction

  initial begin
    int a0, a1;
    txn_t t;
    rst_drv = 1'b1; rst = 1'b1; last = 1;
    issue_pct = 100; abort_pct = 0;
    for (int p = 0; p < 2; p++) begin
      t_adr[p] = '0; t_dat[p] = '0; t_sel[p] = '0; t_we[p] = 1'b0;
      t_stb[p] = 1'b0; t_cyc[p] = 1'b0; act[p] = 1'b0; exp_ack[p] = 1'b0;
      exp_rd[p] = 1'b0; exp_dv[p] = 1'b0; exp_dat[p] = '0; nacks[p] = 0;
      cur[p] = mk(1'b0, '0, '0, '0);
    end
    repeat (2) @(posedge clk);
    step(); step();
    rst_drv = 1'b0;

    // Tie straight after reset: port 0 first.
    qu0.push_back(mk(1'b0, 9'h001, '0, 3'b111));
    qu1.push_back(mk(1'b0, 9'h002, '0, 3'b111));
    run_idle(20);

    // Host write then read-back.
    qu1.push_back(mk(1'b1, 9'h010, 24'hA5B6C7, 3'b111));
    qu1.push_back(mk(1'b0, 9'h010, '0, 3'b111));
    run_idle(20);

    // Single-port streaming.
    for (int i = 0; i < 4; i++) qu0.push_back(mk(1'b0, 9'h010, '0, 3'b111));
    run_idle(20);

    // Both ports busy: alternating grants.
    a0 = nacks[0]; a1 = nacks[1];
    for (int i = 0; i < 3; i++) begin
      qu0.push_back(mk(1'b0, 9'h010, '0, 3'b111));
      qu1.push_back(mk(1'b0, 9'h010, '0, 3'b111));
    end
    run_idle(20);
    chk("rr_acks0", nacks[0] - a0, 3);
    chk("rr_acks1", nacks[1] - a1, 3);

    // Partial byte select still stores the full word.
    qu1.push_back(mk(1'b1, 9'h020, 24'h123456, 3'b001));
    qu1.push_back(mk(1'b0, 9'h020, '0, 3'b111));
    run_idle(20);

    // Reset landing on a grant cycle, then a tie afterwards.
    qu0.push_back(mk(1'b0, 9'h010, '0, 3'b111));
    qu0.push_back(mk(1'b0, 9'h020, '0, 3'b111));
    qu1.push_back(mk(1'b0, 9'h010, '0, 3'b111));
    step();
    rst_drv = 1'b1;
    step(); step();
    rst_drv = 1'b0;
    run_idle(20);

    // Random traffic with aborts and occasional resets.
    issue_pct = 60; abort_pct = 5;
    for (int i = 0; i < 800; i++) begin
      for (int p = 0; p < 2; p++) begin
        if ((p == 0 ? qu0.size() : qu1.size()) < 2) begin
          t = mk(1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom), 3'($urandom_range(7)));
          if (p == 0) qu0.push_back(t); else qu1.push_back(t);
        end
      end
      rst_drv = ($urandom_range(99) == 0);
      step();
    end
    rst_drv = 1'b0; issue_pct = 100; abort_pct = 0;
    run_idle(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
